// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared types for the MAC sequencing controller
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        TAIL  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } mac_ctrl_state_e;

endpackage

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - address/enable sequencer for one pipelined MAC over a fully-connected layer
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int IN_DIM    = 4,
    parameter int OUT_DIM   = 2,
    parameter int ACC_WIDTH = 32,
    parameter int X_AW      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
    parameter int W_AW      = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1,
    parameter int O_IW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [X_AW-1:0]      x_addr,
    output logic [W_AW-1:0]      w_addr,
    output logic                 rd_en,
    output logic                 mac_en,
    output logic                 mac_clr,
    output logic                 op_zero,
    input  logic [ACC_WIDTH-1:0] acc_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic [O_IW-1:0]      res_idx
);

    localparam logic [X_AW-1:0] K_LAST = X_AW'(IN_DIM - 1);
    localparam logic [X_AW-1:0] K_ONE  = X_AW'(1);
    localparam logic [O_IW-1:0] N_LAST = O_IW'(OUT_DIM - 1);

    mac_ctrl_state_e state_q, state_d;
    logic [X_AW-1:0] k_q, k_d;
    logic [O_IW-1:0] n_q, n_d;
    logic [W_AW-1:0] w_q, w_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            w_q     <= w_d;
        end
    end

    // The MAC consumes each operand one cycle after its read, so the
    // enable/clear pattern in FEED/TAIL lags the address sequence by one.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        w_d       = w_q;
        busy      = 1'b0;
        done      = 1'b0;
        x_addr    = '0;
        w_addr    = '0;
        rd_en     = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        op_zero   = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_idx   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FEED;
                    k_d     = '0;
                    n_d     = '0;
                    w_d     = '0;
                end
            end
            FEED: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                x_addr  = k_q;
                w_addr  = w_q;
                mac_en  = (k_q != '0);
                mac_clr = (IN_DIM > 1) && (k_q == K_ONE);
                w_d     = w_q + W_AW'(1);
                if (k_q == K_LAST) begin
                    state_d = TAIL;
                    k_d     = '0;
                end else begin
                    k_d = k_q + X_AW'(1);
                end
            end
            TAIL: begin
                busy    = 1'b1;
                mac_en  = 1'b1;
                // With a single-term dot product the tail cycle is the MAC's first enable.
                mac_clr = (IN_DIM == 1);
                state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                mac_en  = 1'b1;
                op_zero = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_data  = acc_in;
                res_idx   = n_q;
                if (res_ready) begin
                    if (n_q == N_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        n_d     = '0;
                        w_d     = '0;
                    end else begin
                        n_d     = n_q + O_IW'(1);
                        k_d     = '0;
                        state_d = FEED;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed bench for mac_seq_ctrl with ROM and MAC models
module tb_mac_seq_ctrl;

    typedef struct {
        logic       start;
        logic       ready;
        logic [6:0] flg;
        int         xa;
        int         wa;
        int         idx;
        int         data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance 0: IN_DIM=4, OUT_DIM=2
    logic        start0 = 1'b0, ready0 = 1'b0;
    logic        busy0, done0, rd_en0, mac_en0, mac_clr0, op_zero0, res_valid0;
    logic [1:0]  x_addr0;
    logic [2:0]  w_addr0;
    logic [0:0]  res_idx0;
    logic [31:0] res_data0;
    logic signed [31:0] xm0 [4];
    logic signed [31:0] wm0 [8];
    logic signed [31:0] xq0 = 0, wq0 = 0, p0 = 0, acc0 = 0;

    // instance 1: IN_DIM=1, OUT_DIM=2
    logic        start1 = 1'b0, ready1 = 1'b0;
    logic        busy1, done1, rd_en1, mac_en1, mac_clr1, op_zero1, res_valid1;
    logic [0:0]  x_addr1;
    logic [0:0]  w_addr1;
    logic [0:0]  res_idx1;
    logic [31:0] res_data1;
    logic signed [31:0] xm1 [2];
    logic signed [31:0] wm1 [2];
    logic signed [31:0] xq1 = 0, wq1 = 0, p1 = 0, acc1 = 0;

    mac_seq_ctrl #(.IN_DIM(4), .OUT_DIM(2), .ACC_WIDTH(32)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .x_addr(x_addr0), .w_addr(w_addr0), .rd_en(rd_en0), .mac_en(mac_en0),
        .mac_clr(mac_clr0), .op_zero(op_zero0), .acc_in(acc0), .res_valid(res_valid0),
        .res_ready(ready0), .res_data(res_data0), .res_idx(res_idx0)
    );

    mac_seq_ctrl #(.IN_DIM(1), .OUT_DIM(2), .ACC_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .x_addr(x_addr1), .w_addr(w_addr1), .rd_en(rd_en1), .mac_en(mac_en1),
        .mac_clr(mac_clr1), .op_zero(op_zero1), .acc_in(acc1), .res_valid(res_valid1),
        .res_ready(ready1), .res_data(res_data1), .res_idx(res_idx1)
    );

    // 1-cycle ROMs, operand gate and 2-stage MAC (product register, then accumulator)
    always @(posedge clk) begin
        if (rd_en0) begin
            xq0 <= xm0[x_addr0];
            wq0 <= wm0[w_addr0];
        end
        if (mac_en0) begin
            p0   <= op_zero0 ? 32'sd0 : xq0 * wq0;
            acc0 <= mac_clr0 ? 32'sd0 : acc0 + p0;
        end
    end

    always @(posedge clk) begin
        if (rd_en1) begin
            xq1 <= xm1[x_addr1];
            wq1 <= wm1[w_addr1];
        end
        if (mac_en1) begin
            p1   <= op_zero1 ? 32'sd0 : xq1 * wq1;
            acc1 <= mac_clr1 ? 32'sd0 : acc1 + p1;
        end
    end

    int men_cnt0  = 0;
    int done_cnt0 = 0;
    always @(negedge clk) begin
        if (mac_en0) men_cnt0 <= men_cnt0 + 1;
        if (done0)   done_cnt0 <= done_cnt0 + 1;
    end

    function automatic logic [6:0] get_flg(input int sel);
        if (sel == 0) return {busy0, done0, rd_en0, mac_en0, mac_clr0, op_zero0, res_valid0};
        return {busy1, done1, rd_en1, mac_en1, mac_clr1, op_zero1, res_valid1};
    endfunction

    function automatic int get_x(input int sel);
        return (sel == 0) ? int'(x_addr0) : int'(x_addr1);
    endfunction

    function automatic int get_w(input int sel);
        return (sel == 0) ? int'(w_addr0) : int'(w_addr1);
    endfunction

    function automatic int get_i(input int sel);
        return (sel == 0) ? int'(res_idx0) : int'(res_idx1);
    endfunction

    function automatic int get_d(input int sel);
        return (sel == 0) ? int'($signed(res_data0)) : int'($signed(res_data1));
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [6:0] f,
                                input int x, input int w, input int i, input int d);
        vec_t v;
        v.start = s; v.ready = r; v.flg = f; v.xa = x; v.wa = w; v.idx = i; v.data = d;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic s, input logic r);
        if (sel == 0) begin start0 = s; ready0 = r; end
        else begin start1 = s; ready1 = r; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int sel, input vec_t tv[$]);
        foreach (tv[i]) begin
            set_in(sel, tv[i].start, tv[i].ready);
            @(negedge clk);
            chk($sformatf("t%0d_c%0d_flags", sel, i), int'(get_flg(sel)), int'(tv[i].flg));
            chk($sformatf("t%0d_c%0d_xaddr", sel, i), get_x(sel), tv[i].xa);
            chk($sformatf("t%0d_c%0d_waddr", sel, i), get_w(sel), tv[i].wa);
            chk($sformatf("t%0d_c%0d_idx", sel, i), get_i(sel), tv[i].idx);
            chk($sformatf("t%0d_c%0d_data", sel, i), get_d(sel), tv[i].data);
            step();
        end
        set_in(sel, 1'b0, 1'b0);
    endtask

    // Runs one layer on instance 0 with res_ready high and checks both results.
    task automatic layer_check(input string tag, input int e0, input int e1);
        bit found;
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int r = 0; r < 2; r++) begin
            found = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (res_valid0) begin
                    found = 1;
                    break;
                end
                step();
            end
            chk($sformatf("%s_found%0d", tag, r), int'(found), 1);
            chk($sformatf("%s_idx%0d", tag, r), get_i(0), r);
            chk($sformatf("%s_data%0d", tag, r), get_d(0), (r == 0) ? e0 : e1);
            chk($sformatf("%s_done%0d", tag, r), int'(done0), (r == 1) ? 1 : 0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv0[$];
        vec_t tv1[$];
        int m_base, d_base, nres, r0, r1;
        bit found;

        xm0[0] = 1; xm0[1] = 2; xm0[2] = 3; xm0[3] = 4;
        wm0[0] = 1; wm0[1] = 1; wm0[2] = 1; wm0[3] = 1;
        wm0[4] = 2; wm0[5] = -1; wm0[6] = 0; wm0[7] = 3;
        xm1[0] = -5; xm1[1] = 0;
        wm1[0] = 3; wm1[1] = -2;

        tv0.push_back(mk(1, 1, 7'b0000000, 0, 0, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1010000, 0, 0, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1011100, 1, 1, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1011000, 2, 2, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1011000, 3, 3, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1001000, 0, 0, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1001010, 0, 0, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1000001, 0, 0, 0, 10));
        tv0.push_back(mk(0, 1, 7'b1010000, 0, 4, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1011100, 1, 5, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1011000, 2, 6, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1011000, 3, 7, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1001000, 0, 0, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1001010, 0, 0, 0, 0));
        tv0.push_back(mk(0, 1, 7'b1100001, 0, 0, 1, 12));
        tv0.push_back(mk(0, 1, 7'b0000000, 0, 0, 0, 0));

        tv1.push_back(mk(1, 1, 7'b0000000, 0, 0, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1010000, 0, 0, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1001100, 0, 0, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1001010, 0, 0, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1000001, 0, 0, 0, -15));
        tv1.push_back(mk(0, 1, 7'b1010000, 0, 1, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1001100, 0, 0, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1001010, 0, 0, 0, 0));
        tv1.push_back(mk(0, 1, 7'b1100001, 0, 0, 1, 10));
        tv1.push_back(mk(0, 1, 7'b0000000, 0, 0, 0, 0));

        // reset state, with start and res_ready driven high to show they are ignored
        start0 = 1'b1; ready0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags0", int'(get_flg(0)), 0);
        chk("rst_addr0", get_x(0) + get_w(0) + get_i(0), 0);
        chk("rst_flags1", int'(get_flg(1)), 0);
        start0 = 1'b0; ready0 = 1'b0;
        step();
        rst = 1'b0;
        step();

        run_table(0, tv0);
        run_table(1, tv1);

        // backpressure at idx0
        ready0 = 1'b0;
        m_base = men_cnt0;
        d_base = done_cnt0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid0) begin
                found = 1;
                break;
            end
            step();
        end
        chk("bp_found", int'(found), 1);
        for (int h = 0; h < 5; h++) begin
            if (h > 0) begin
                step();
                @(negedge clk);
            end
            chk($sformatf("bp_hold%0d_valid", h), int'(res_valid0), 1);
            chk($sformatf("bp_hold%0d_data", h), get_d(0), 10);
            chk($sformatf("bp_hold%0d_idx", h), get_i(0), 0);
            chk($sformatf("bp_hold%0d_mac_en", h), int'(mac_en0), 0);
        end
        step();
        ready0 = 1'b1;
        @(negedge clk);
        chk("bp_release_data", get_d(0), 10);
        chk("bp_release_done", int'(done0), 0);
        step();
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid0) begin
                found = 1;
                break;
            end
            step();
        end
        chk("bp_found1", int'(found), 1);
        chk("bp_idx1", get_i(0), 1);
        chk("bp_data1", get_d(0), 12);
        chk("bp_done1", int'(done0), 1);
        step();
        chk("bp_mac_en_pulses", men_cnt0 - m_base, 10);
        chk("bp_done_pulses", done_cnt0 - d_base, 1);

        // back-to-back layers: start in the cycle right after done
        layer_check("b2b_a", 10, 12);
        layer_check("b2b_b", 10, 12);

        // start held high while busy
        ready0 = 1'b1;
        d_base = done_cnt0;
        nres = 0; r0 = 0; r1 = 0;
        start0 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 11) start0 = 1'b0;
            @(negedge clk);
            if (res_valid0) begin
                if (nres == 0) r0 = get_d(0);
                else r1 = get_d(0);
                nres++;
            end
            step();
        end
        chk("busy_start_nres", nres, 2);
        chk("busy_start_r0", r0, 10);
        chk("busy_start_r1", r1, 12);
        chk("busy_start_done", done_cnt0 - d_base, 1);

        // async reset during FEED of idx1
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (8) step();
        chk("rst_mid_busy", int'(busy0), 1);
        chk("rst_mid_waddr", get_w(0), 5);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", int'(get_flg(0)), 0);
        chk("rst_mid_addr", get_x(0) + get_w(0) + get_i(0) + get_d(0), 0);
        step();
        rst = 1'b0;
        step();
        layer_check("after_rst", 10, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for one pipelined signed MAC unit that computes a fully-connected layer of OUT_DIM neurons, each a dot product over IN_DIM inputs. It issues weight and input memory addresses and drives the MAC's enable and clear. It gates the MAC operands during the pipeline drain cycle, then presents each finished accumulator value on a valid/ready result port. It sits between the layer's synchronous weight/input memories (1-cycle read latency) and the layer output buffer.

## Interface
- IN_DIM, 4, dot-product length per neuron (≥1)
- OUT_DIM, 2, neurons per layer (≥1)
- ACC_WIDTH, 32, MAC accumulator width
- X_AW, max(1,$clog2(IN_DIM)), input address width
- W_AW, max(1,$clog2(IN_DIM*OUT_DIM)), weight address width
- O_IW, max(1,$clog2(OUT_DIM)), neuron index width
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- x_addr  out  X_AW  input memory read address
- w_addr  out  W_AW  weight memory read address
- rd_en  out  1  memory read strobe; data valid the next cycle
- mac_en  out  1  to MAC enable
- mac_clr  out  1  to MAC clear
- op_zero  out  1  forces MAC operands a=b=0 (datapath mux outside this block)
- acc_in  in  ACC_WIDTH  MAC accumulator output
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  ACC_WIDTH  equals acc_in while res_valid
- res_idx  out  O_IW  neuron index of res_data

## Operation
- States: IDLE → FEED → TAIL → DRAIN → OUT → (FEED | IDLE).
- IDLE: all outputs 0; start=1 → FEED, k=0, n=0, w_addr counter=0.
- FEED: lasts IN_DIM cycles. Each cycle rd_en=1, x_addr=k, w_addr=n*IN_DIM+k; w_addr comes from a running counter, never a multiplier.
  - mac_en=1 when k>0; mac_clr=1 when k==1. Together these consume the operand read the cycle before.
  - k==IN_DIM-1 → TAIL.
- TAIL: rd_en=0, mac_en=1 (consumes operand IN_DIM-1); mac_clr=1 only if IN_DIM==1.
- DRAIN: mac_en=1, op_zero=1. The MAC adds the last product; its stage-1 register loads 0.
- OUT: res_valid=1, res_idx=n, mac_en=0 so acc_in is stable.
  - res_ready=1 and n<OUT_DIM-1 → n+1, k=0, FEED.
  - res_ready=1 and n==OUT_DIM-1 → done=1 in that same cycle, then IDLE.
- The MAC's first enabled cycle always has clear=1. Stale stage-1 contents from the previous neuron are never accumulated.
- start outside IDLE is ignored. res_ready outside OUT is ignored.
- rst asserted in any state: async return to IDLE with all counters 0 and all outputs 0. The MAC's own reset is handled externally.

## Timing
- Start accepted in cycle 0. FEED occupies cycles 1..IN_DIM, TAIL is IN_DIM+1, DRAIN is IN_DIM+2, and res_valid first rises in cycle IN_DIM+3.
- Per neuron with no backpressure: IN_DIM+3 cycles (FEED+TAIL+DRAIN+one OUT cycle).
- Layer of L neurons with res_ready tied high: L*(IN_DIM+3) cycles from the first FEED cycle to done.
- Backpressure: OUT holds indefinitely; res_data, res_idx and res_valid stay stable until the handshake.
- Reset values: busy=done=rd_en=mac_en=mac_clr=op_zero=res_valid=0; x_addr=w_addr=res_idx=0.

## Structure
- Package mac_ctrl_pkg: state enum type mac_ctrl_state_e (IDLE, FEED, TAIL, DRAIN, OUT).
- Sub-module: none required. The k and n counters are inline.
- The MAC and the memories are instantiated by the layer wrapper, not inside this block.

## Test plan
Bench: IN_DIM=4, OUT_DIM=2, x=[1,2,3,4], W rows [1,1,1,1] and [2,-1,0,3], real MAC, 1-cycle ROMs.
- Basic layer, start at cycle 0, res_ready=1 → res_valid at cycle 7 with (idx0, 10); cycle 14 with (idx1, 12); done pulses at cycle 14.
- Backpressure: res_ready=0 for 5 cycles at idx0 → res_data held at 10; idx1 still 12; no extra mac_en pulses.
- Back-to-back layers: start re-asserted the cycle after done → identical results, no carry-over from the previous accumulation.
- start pulsed while busy → ignored; results unchanged; exactly one done.
- rst asserted during FEED of idx1 → outputs 0 in the same cycle; a fresh start yields 10 then 12.
- IN_DIM=1, x=[-5], W=[[3],[-2]] → results -15 then 10; mac_clr asserted in TAIL.
